// File: rtl/diagonal_sched.sv
// Two-requester counter scheduler: X and Y climb under round-robin arbitration
// with Y never passing X, saturate in FULL, and drain back to zero on clr.
module diagonal_sched #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_x,
    input  logic         req_y,
    input  logic         clr,
    output logic         gnt_x,
    output logic         gnt_y,
    output logic [W-1:0] X,
    output logic [W-1:0] Y,
    output logic         full,
    output logic         done,
    output logic [1:0]   state_dbg
);

    localparam logic [W-1:0] KMAX = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Initializers match the reset values so formal runs start from reset state.
    state_t       state_q = RUN;
    logic         rr_q    = 1'b0;
    logic [W-1:0] x_q     = '0;
    logic [W-1:0] y_q     = '0;

    logic         arb_ok;
    logic         cand_x;
    logic         cand_y;
    logic [W-1:0] x_nxt;
    logic [W-1:0] y_nxt;

    // Handshake: req_x/req_y are requests; gnt_x/gnt_y mean the matching counter
    // advances by one at this posedge. A request without a grant is simply dropped.
    assign arb_ok = (state_q == RUN) && !clr && !reset;
    assign cand_x = req_x && (x_q != KMAX);
    assign cand_y = req_y && (y_q < x_q);

    assign gnt_x = arb_ok && cand_x && (!cand_y || !rr_q);
    assign gnt_y = arb_ok && cand_y && (!cand_x || rr_q);

    assign x_nxt = x_q + {{(W-1){1'b0}}, gnt_x};
    assign y_nxt = y_q + {{(W-1){1'b0}}, gnt_y};

    assign X         = x_q;
    assign Y         = y_q;
    assign full      = (state_q == FULL) && !reset;
    assign done      = (state_q == DRAIN) && (x_q == '0) && (y_q == '0) && !reset;
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            rr_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (clr) begin
                        state_q <= DRAIN;
                    end else begin
                        x_q <= x_nxt;
                        y_q <= y_nxt;
                        if (gnt_x) rr_q <= 1'b1;
                        if (gnt_y) rr_q <= 1'b0;
                        if ((x_nxt == KMAX) && (y_nxt == KMAX)) state_q <= FULL;
                    end
                end
                FULL: begin
                    if (clr) state_q <= DRAIN;
                end
                DRAIN: begin
                    // Drain Y first so Y <= X holds on every step down.
                    if (y_q != '0) begin
                        y_q <= y_q - 1'b1;
                    end else if (x_q != '0) begin
                        x_q <= x_q - 1'b1;
                    end else begin
                        state_q <= RUN;
                        rr_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN;
                    rr_q    <= 1'b0;
                    x_q     <= '0;
                    y_q     <= '0;
                end
            endcase
        end
    end

    ap_y_le_x: assert property (@(posedge clk) disable iff (reset) (y_q <= x_q));
    ap_done_in_drain: assert property (@(posedge clk) disable iff (reset)
        (done |-> (state_q == DRAIN)));
    ap_full_done_excl: assert property (@(posedge clk) disable iff (reset)
        !(full && done));

endmodule

// File: tb/tb_diagonal_sched.sv
// Directed bench for diagonal_sched: arbitration order, eligibility, saturation,
// drain sequencing and reset behaviour, each in its own task.
module tb_diagonal_sched;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_x;
    logic         req_y;
    logic         clr;
    logic         gnt_x;
    logic         gnt_y;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         full;
    logic         done;
    logic [1:0]   state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    diagonal_sched #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_x     (req_x),
        .req_y     (req_y),
        .clr       (clr),
        .gnt_x     (gnt_x),
        .gnt_y     (gnt_y),
        .X         (X),
        .Y         (Y),
        .full      (full),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_x = 1'b0;
        req_y = 1'b0;
        clr   = 1'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_x = 1'b1;
        req_y = 1'b1;
        clr   = 1'b1;
        #2;
        total_cnt++;
        if ({gnt_x, gnt_y, full, done} !== 4'b0000)
            $display("FAIL reset_outputs: got %b expected 0000", {gnt_x, gnt_y, full, done});
        else pass_cnt++;
        tick();
        reset = 1'b0;
        req_x = 1'b0;
        req_y = 1'b0;
        clr   = 1'b0;
        #1;
        total_cnt++;
        if ({state_dbg, X, Y} !== {S_RUN, 4'd0, 4'd0})
            $display("FAIL reset_state: got st=%0d X=%0d Y=%0d expected st=0 X=0 Y=0",
                     state_dbg, X, Y);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gx = 4'b0101;  // bit i = gnt_x in cycle i: x,y,x,y
        int exp_x[4] = '{1, 1, 2, 2};
        int exp_y[4] = '{0, 1, 1, 2};
        apply_reset();
        req_x = 1'b1;
        req_y = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if ({gnt_x, gnt_y} !== {exp_gx[i], ~exp_gx[i]})
                $display("FAIL rr_grant[%0d]: got gx=%b gy=%b expected gx=%b gy=%b",
                         i, gnt_x, gnt_y, exp_gx[i], ~exp_gx[i]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (X !== W'(exp_x[i]) || Y !== W'(exp_y[i]))
                $display("FAIL rr_count[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                         i, X, Y, exp_x[i], exp_y[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_y_blocked();
        // continue from (2,2): x then y brings the pair to (3,3)
        tick();
        tick();
        req_x = 1'b0;
        req_y = 1'b1;
        #1;
        total_cnt++;
        if (X !== 4'd3 || Y !== 4'd3 || gnt_y !== 1'b0 || gnt_x !== 1'b0)
            $display("FAIL y_blocked_grant: got X=%0d Y=%0d gy=%b gx=%b expected 3 3 0 0",
                     X, Y, gnt_y, gnt_x);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (Y !== 4'd3)
            $display("FAIL y_blocked_hold: got Y=%0d expected 3", Y);
        else pass_cnt++;
        req_x = 1'b1;
        req_y = 1'b0;
        #1;
        total_cnt++;
        if (gnt_x !== 1'b1)
            $display("FAIL x_alone_grant: got gx=%b expected 1", gnt_x);
        else pass_cnt++;
        req_x = 1'b0;
    endtask

    task automatic test_clr_drain();
        int seq_x[6] = '{3, 3, 3, 2, 1, 0};
        int seq_y[6] = '{2, 1, 0, 0, 0, 0};
        apply_reset();
        req_x = 1'b1;
        req_y = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        req_y = 1'b0;
        clr   = 1'b1;
        #1;
        total_cnt++;
        if (X !== 4'd3 || Y !== 4'd2 || gnt_x !== 1'b0 || gnt_y !== 1'b0)
            $display("FAIL clr_wins: got X=%0d Y=%0d gx=%b gy=%b expected 3 2 0 0",
                     X, Y, gnt_x, gnt_y);
        else pass_cnt++;
        tick();
        clr = 1'b0;
        total_cnt++;
        if (state_dbg !== S_DRAIN)
            $display("FAIL drain_entry: got state=%0d expected 2", state_dbg);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (X !== W'(seq_x[i]) || Y !== W'(seq_y[i]) || done !== (i == 5) ||
                gnt_x !== 1'b0 || gnt_y !== 1'b0)
                $display("FAIL drain_step[%0d]: got (%0d,%0d) done=%b gx=%b expected (%0d,%0d) done=%b gx=0",
                         i, X, Y, done, gnt_x, seq_x[i], seq_y[i], (i == 5));
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (state_dbg !== S_RUN || done !== 1'b0)
            $display("FAIL drain_exit: got state=%0d done=%b expected 0 0", state_dbg, done);
        else pass_cnt++;
        req_x = 1'b0;
    endtask

    task automatic test_clr_at_zero();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total_cnt++;
        if (state_dbg !== S_DRAIN || done !== 1'b1)
            $display("FAIL zero_drain: got state=%0d done=%b expected 2 1", state_dbg, done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (state_dbg !== S_RUN || done !== 1'b0)
            $display("FAIL zero_drain_exit: got state=%0d done=%b expected 0 0", state_dbg, done);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        req_x = 1'b1;
        req_y = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        req_x = 1'b0;
        req_y = 1'b0;
        clr   = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        total_cnt++;
        if (state_dbg !== S_DRAIN || X !== 4'd2 || Y !== 4'd0 || done !== 1'b0)
            $display("FAIL mid_drain_pos: got st=%0d (%0d,%0d) done=%b expected 2 (2,0) 0",
                     state_dbg, X, Y, done);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (done !== 1'b0)
            $display("FAIL mid_drain_done: got done=%b expected 0", done);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        #1;
        total_cnt++;
        if (state_dbg !== S_RUN || X !== 4'd0 || Y !== 4'd0 || done !== 1'b0)
            $display("FAIL mid_drain_abort: got st=%0d (%0d,%0d) done=%b expected 0 (0,0) 0",
                     state_dbg, X, Y, done);
        else pass_cnt++;
    endtask

    task automatic test_full_and_long_drain();
        int n;
        apply_reset();
        req_x = 1'b1;
        req_y = 1'b1;
        n = 0;
        while (full !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n !== 30 || X !== 4'd15 || Y !== 4'd15 || state_dbg !== S_FULL)
            $display("FAIL full_reach: got cycles=%0d (%0d,%0d) st=%0d expected 30 (15,15) 1",
                     n, X, Y, state_dbg);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (gnt_x !== 1'b0 || gnt_y !== 1'b0 || full !== 1'b1 || done !== 1'b0 ||
                X !== 4'd15 || Y !== 4'd15)
                $display("FAIL full_hold[%0d]: got gx=%b gy=%b full=%b done=%b (%0d,%0d) expected 0 0 1 0 (15,15)",
                         i, gnt_x, gnt_y, full, done, X, Y);
            else pass_cnt++;
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            total_cnt++;
            if (full !== 1'b0)
                $display("FAIL drain_full_low[%0d]: got full=%b expected 0", n, full);
            else pass_cnt++;
            tick();
            n++;
        end
        total_cnt++;
        if (n !== 31 || X !== 4'd0 || Y !== 4'd0)
            $display("FAIL long_drain_len: got cycles=%0d (%0d,%0d) expected 31 (0,0)", n, X, Y);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (state_dbg !== S_RUN)
            $display("FAIL long_drain_exit: got state=%0d expected 0", state_dbg);
        else pass_cnt++;
        req_x = 1'b0;
        req_y = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_y_blocked();
        test_clr_drain();
        test_clr_at_zero();
        test_reset_mid_drain();
        test_full_and_long_drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
